// File: rtl/sar_avg_fifo.sv
// SAR result averager: accumulates 2^AVG_LOG2 conversion results per average
// and queues each truncated average in a small output FIFO with a sticky drop flag.
module sar_avg_fifo #(
  parameter int DATA_W     = 12,
  parameter int AVG_LOG2   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             bitout_in,
  input  logic                          conv_done,
  input  logic                          clr,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int SCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SCNT_W-1:0] SMP_LAST = SCNT_W'((1 << AVG_LOG2) - 1);

  logic              conv_prev_r;
  logic [ACC_W-1:0]  acc_r;
  logic [SCNT_W-1:0] smp_cnt_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              valid_r;
  logic              overflow_r;
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];

  logic              sample_s;
  logic              last_s;
  logic [ACC_W-1:0]  sum_s;
  logic [DATA_W-1:0] avg_s;
  logic              pop_s;
  logic              full_s;
  logic              wr_en_s;
  logic              drop_s;
  logic [CNT_W-1:0]  count_nxt_s;

  // Sample-event detection, averaging and FIFO push/pop decisions
  always_comb begin
    sample_s = conv_done & ~conv_prev_r;
    last_s   = sample_s && (smp_cnt_r == SMP_LAST);
    sum_s    = acc_r + ACC_W'(bitout_in);
    avg_s    = DATA_W'(sum_s >> AVG_LOG2);
    pop_s    = valid_r & out_ready;
    full_s   = (count_r == CNT_W'(FIFO_DEPTH));
    // When full, a push only lands if the head leaves on the same edge
    wr_en_s  = last_s & (~full_s | pop_s);
    drop_s   = last_s & full_s & ~pop_s;
    case ({wr_en_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Control state: edge history, accumulator, pointers, occupancy, sticky flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conv_prev_r <= 1'b1;
      acc_r       <= '0;
      smp_cnt_r   <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      valid_r     <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      conv_prev_r <= conv_done;
      if (clr) begin
        acc_r      <= '0;
        smp_cnt_r  <= '0;
        wr_ptr_r   <= '0;
        rd_ptr_r   <= '0;
        count_r    <= '0;
        valid_r    <= 1'b0;
        overflow_r <= 1'b0;
      end else begin
        if (sample_s) begin
          if (last_s) begin
            acc_r     <= '0;
            smp_cnt_r <= '0;
          end else begin
            acc_r     <= sum_s;
            smp_cnt_r <= smp_cnt_r + SCNT_W'(1);
          end
        end
        if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        if (drop_s)  overflow_r <= 1'b1;
        count_r <= count_nxt_s;
        valid_r <= (count_nxt_s != '0);
      end
    end
  end

  // FIFO storage; contents are don't-care until written, head is gated below
  always_ff @(posedge clk) begin
    if (wr_en_s && !clr) mem_r[wr_ptr_r] <= avg_s;
  end

  // Head word is forced to zero whenever nothing valid is held
  always_comb begin
    if (valid_r) out_data = mem_r[rd_ptr_r];
    else         out_data = '0;
  end

  assign out_valid  = valid_r;
  assign fifo_count = count_r;
  assign overflow   = overflow_r;

endmodule

// File: doc/sar_avg_fifo.md
SAR_AVG_FIFO -- requirements
Module: sar_avg_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 12: width of the SAR result word.
REQ-002 SHALL have parameter AVG_LOG2, default 2, legal 0..4: log2 of the number of samples averaged per output.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, power of two: number of output FIFO entries.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 bitout_in  input  DATA_W  conversion result from the SAR logic stage.
REQ-007 conv_done  input  1  SAR conversion-complete level; bitout_in is valid while high.
REQ-008 clr  input  1  synchronous clear of accumulator, FIFO and overflow flag.
REQ-009 out_data  output  DATA_W  averaged result at the FIFO head.
REQ-010 out_valid  output  1  FIFO not empty; out_data is valid.
REQ-011 out_ready  input  1  consumer accepts out_data.
REQ-012 fifo_count  output  clog2(FIFO_DEPTH)+1  number of entries held.
REQ-013 overflow  output  1  sticky flag: an average was dropped because the FIFO was full.

Function
REQ-014 SHALL detect a sample event on a clock edge where conv_done=1 and its registered previous value is 0 (rising edge only).
REQ-015 A conv_done level held high SHALL produce exactly one sample event.
REQ-016 On a sample event, bitout_in SHALL be added to an accumulator of DATA_W+AVG_LOG2 bits, and the sample counter SHALL increment.
REQ-017 The accumulator SHALL never overflow, since the maximum is 2^AVG_LOG2 samples of all-ones.
REQ-018 On the sample event with counter = 2^AVG_LOG2-1, the block SHALL form avg = (acc + bitout_in) >> AVG_LOG2, truncating toward zero.
REQ-019 On that same edge, avg SHALL be pushed into the FIFO, and the accumulator and counter SHALL be zeroed.
REQ-020 With AVG_LOG2=0, every sample event SHALL push bitout_in unchanged.
REQ-021 Latency: a pushed word SHALL be visible on out_data, with out_valid=1, in the cycle after the push edge, provided the FIFO was empty.
REQ-022 Pop: a word SHALL be removed on an edge where out_valid=1 and out_ready=1; out_ready while out_valid=0 SHALL be ignored.
REQ-023 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-024 Push when full with no pop: the word SHALL be dropped, FIFO contents SHALL be unchanged, and overflow SHALL be set to 1.
REQ-025 Push when full with a simultaneous pop: both SHALL take effect, fifo_count SHALL stay at FIFO_DEPTH, and overflow SHALL be unchanged.
REQ-026 Push and pop in the same cycle at any other count: both SHALL take effect and fifo_count SHALL be unchanged.
REQ-027 Push when empty: the word SHALL NOT bypass the FIFO to out_data in the push cycle.
REQ-028 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 overflow SHALL clear only on reset or clr.
REQ-030 clr=1 SHALL zero the accumulator, counter, FIFO pointers, fifo_count and overflow on that edge.
REQ-031 clr SHALL take priority over a sample event or pop in the same cycle, and such an event or pop SHALL be lost.

Reset
REQ-032 While reset=1, out_valid=0, fifo_count=0, overflow=0, accumulator=0 and counter=0, and out_data SHALL equal 0.
REQ-033 The registered previous conv_done SHALL reset to 1, so that conv_done high at reset release is not a sample event.
REQ-034 Reset asserted mid-accumulation SHALL discard partial sums, and the first post-reset output SHALL use only post-reset samples.

Verification
REQ-035 AVG_LOG2=2; apply samples 0x100, 0x101, 0x102, 0x104 -> one push, out_data=0x101, out_valid=1 one cycle after the 4th event.
REQ-036 AVG_LOG2=2; apply four samples of 0xFFF -> out_data=0xFFF, with no accumulator wrap.
REQ-037 AVG_LOG2=0; hold conv_done high for 10 cycles with bitout_in=0xABC -> exactly one push, fifo_count=1.
REQ-038 AVG_LOG2=0 with out_ready=0; apply 5 events with values 1..5 -> fifo_count=4 and overflow=1; then with out_ready=1, reads are 1, 2, 3, 4 and out_valid falls.
REQ-039 FIFO full; apply an event together with out_ready=1 -> fifo_count stays 4, overflow stays 0, and the new word appears last.
REQ-040 AVG_LOG2=2; apply 2 samples, pulse reset, then apply 4 samples of 0x010 -> out_data=0x010.
